multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-003 SHALL have port Instr, input, 12, instruction bits [31:20]: cond[11:8], op[7:6], funct[5:0].
REQ-004 SHALL have port Rd, input, 4, instruction bits [15:12].
REQ-005 SHALL have port ALUFlags, input, 4, NZCV from the ALU in the current cycle.
REQ-006 SHALL have outputs PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, each 1 bit: datapath enables and selects.
REQ-007 SHALL have outputs ResultSrc, ALUSrcB, ImmSrc, RegSrc, each 2 bits: datapath selects.
REQ-008 SHALL have output ALUControl, 4 bits: ADD 0011, SUB 0100, AND 0000, ORR 0001.
REQ-009 SHALL have output Flags, 4 bits: registered NZCV.

Function
REQ-010 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
REQ-011 FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10; next DECODE.
REQ-012 DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10; next MEMADR if op=01, EXECI if op=00 and funct[5]=1, EXECR if op=00 and funct[5]=0, BRANCH if op=10, FETCH if op=11.
REQ-013 MEMADR: ALUSrcB=01, ImmSrc=01, ALUControl=ADD if funct[3]=1 else SUB; next MEMRD if funct[0]=1 else MEMWR.
REQ-014 MEMRD: AdrSrc=1; next MEMWB. MEMWB: ResultSrc=01, RegWrite=CondEx; next FETCH.
REQ-015 MEMWR: AdrSrc=1, MemWrite=CondEx, RegSrc=10; next FETCH.
REQ-016 EXECR: ALUSrcB=00; EXECI: ALUSrcB=01, ImmSrc=00; both decode ALUControl from funct[4:1] (0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, other ADD); next ALUWB.
REQ-017 ALUWB: ResultSrc=00, RegWrite=CondEx and op≠CMP (funct[4:1]=1010 treated as SUB, RegWrite=0); next FETCH.
REQ-018 BRANCH: ALUSrcB=01, ImmSrc=10, ALUControl=ADD, ResultSrc=10, PCWrite=CondEx; next FETCH.
REQ-019 In MEMWB and ALUWB with Rd=1111, PCWrite SHALL equal CondEx.
REQ-020 CondEx SHALL evaluate cond against registered Flags per ARM (EQ..LE, 1110 always true, 1111 false).
REQ-021 Flags SHALL update at the end of EXECR/EXECI only when funct[0]=1 and CondEx: NZ always, CV only for ADD/SUB.
REQ-022 Outputs not listed for a state SHALL be 0; latency: data-processing 4 cycles, LDR 5, STR 4, B 3, op=11 2.

Reset
REQ-023 reset low SHALL force state FETCH and Flags=0000 immediately, regardless of current state.
REQ-024 While reset is low, PCWrite, IRWrite, MemWrite and RegWrite SHALL be 0.
REQ-025 First FETCH actions SHALL occur on the first rising edge after reset deasserts.

Structure
REQ-026 A shared package ctrl_pkg SHALL hold the state enum, ALUControl encodings and ResultSrc/ImmSrc encodings.
REQ-027 Condition evaluation SHALL be a sub-module cond_check (inputs cond, Flags; output CondEx).

Verification
REQ-028 ADD immediate, Instr=0xE28, Rd=0001 -> FETCH,DECODE,EXECI,ALUWB; RegWrite=1 only in ALUWB; ALUControl=0011.
REQ-029 SUBS register producing zero, Instr=0xE05, ALUFlags=0100 -> Flags=0100 after EXECR; next BEQ (0x0A0) PCWrite=1 in BRANCH.
REQ-030 BNE (0x1A0) with Flags Z=1 -> BRANCH state reached, PCWrite=0.
REQ-031 LDR (0xE59) -> 5 states, RegWrite=1 in MEMWB, ResultSrc=01; STR (0xE58) -> MemWrite=1 in MEMWR only.
REQ-032 reset pulled low during MEMRD -> state FETCH and Flags=0000 without clock edge; all write enables 0.
REQ-033 op=11 instruction -> FETCH, DECODE, FETCH; no RegWrite/MemWrite asserted.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM states, ALU and mux encodings.
// Latency: n/a (definitions only).
// Backpressure: n/a.
//
// Contents:
//   state_t           - controller FSM states
//   ALU_*             - ALUControl encodings driven to the datapath ALU
//   RES_*, IMM_*      - ResultSrc / ImmSrc mux encodings
//   SRCB_*            - ALUSrcB mux encodings
//   OP_*, CMD_*       - instruction field values decoded by the controller
//   dp_alu_control()  - data-processing cmd -> ALUControl
//   dp_sets_cv()      - whether a data-processing cmd may update C and V
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    // ALUControl encodings
    localparam logic [3:0] ALU_ADD = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_ORR = 4'b0001;

    // ResultSrc: 00 registered ALU result, 01 memory read data, 10 raw ALU output
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // ImmSrc: 00 8-bit data-processing immediate, 01 12-bit offset, 10 24-bit branch
    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    // ALUSrcB: 00 register, 01 extended immediate, 10 constant four
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // RegSrc used by stores to read the data register through the Rd field
    localparam logic [1:0] REGSRC_STR = 2'b10;

    // op field
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // data-processing cmd field (funct[4:1])
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    // Unknown commands fall back to ADD so the datapath always does something defined.
    function automatic logic [3:0] dp_alu_control(input logic [3:0] cmd);
        logic [3:0] ctl;
        case (cmd)
            CMD_ADD: ctl = ALU_ADD;
            CMD_SUB: ctl = ALU_SUB;
            CMD_CMP: ctl = ALU_SUB;
            CMD_AND: ctl = ALU_AND;
            CMD_ORR: ctl = ALU_ORR;
            default: ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

    // Carry and overflow are only meaningful for the arithmetic operations.
    function automatic logic dp_sets_cv(input logic [3:0] cmd);
        logic [3:0] ctl;
        ctl = dp_alu_control(cmd);
        return (ctl == ALU_ADD) || (ctl == ALU_SUB);
    endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluation of cond against the registered NZCV flags.
// Latency: combinational, 0 cycles.
// Backpressure: none.
//
// Ports:
//   cond   [3:0] - condition field of the current instruction
//   Flags  [3:0] - registered flags, {N, Z, C, V}
//   CondEx       - 1 when the instruction should take effect
module cond_check
    import ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;
    logic ge;

    assign n  = Flags[3];
    assign z  = Flags[2];
    assign c  = Flags[1];
    assign v  = Flags[0];
    assign ge = (n == v);

    always_comb begin
        CondEx = 1'b0;
        case (cond)
            4'b0000: CondEx = z;              // EQ
            4'b0001: CondEx = ~z;             // NE
            4'b0010: CondEx = c;              // CS/HS
            4'b0011: CondEx = ~c;             // CC/LO
            4'b0100: CondEx = n;              // MI
            4'b0101: CondEx = ~n;             // PL
            4'b0110: CondEx = v;              // VS
            4'b0111: CondEx = ~v;             // VC
            4'b1000: CondEx = c & ~z;         // HI
            4'b1001: CondEx = ~c | z;         // LS
            4'b1010: CondEx = ge;             // GE
            4'b1011: CondEx = ~ge;            // LT
            4'b1100: CondEx = ~z & ge;        // GT
            4'b1101: CondEx = z | ~ge;        // LE
            4'b1110: CondEx = 1'b1;           // AL
            default: CondEx = 1'b0;           // 1111 never executes
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-FSM controller for a multicycle ARM-subset datapath, plus the NZCV flag register.
// Latency: data-processing 4 cycles, LDR 5, STR 4, B 3, op=11 2 (FETCH..last state).
// Backpressure: none; advances one state per clock, reset forces FETCH asynchronously.
//
// Ports:
//   clk, reset (async, active low)
//   Instr[11:0] = {cond, op, funct}, Rd[3:0], ALUFlags[3:0] = NZCV from the ALU
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA  - enables / 1-bit selects
//   ResultSrc, ALUSrcB, ImmSrc, RegSrc                     - 2-bit selects
//   ALUControl[3:0], Flags[3:0] (registered NZCV)
module multicycle_controller
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] Instr,
    input  logic [3:0]  Rd,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [3:0]  ALUControl,
    output logic [3:0]  Flags
);

    state_t      state;
    state_t      next_state;
    logic [3:0]  flags_q;
    logic        cond_ex;
    logic        flag_wr;
    logic        pc_is_rd;

    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  cmd;

    assign op       = Instr[7:6];
    assign funct    = Instr[5:0];
    assign cmd      = funct[4:1];
    assign pc_is_rd = (Rd == 4'b1111);
    assign Flags    = flags_q;

    cond_check u_cond_check (
        .cond   (Instr[11:8]),
        .Flags  (flags_q),
        .CondEx (cond_ex)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Flag register: written as the execute state completes, for S-suffixed
    // instructions that pass their condition. Logical ops keep C and V.
    // ------------------------------------------------------------------
    assign flag_wr = ((state == S_EXECR) || (state == S_EXECI)) && funct[0] && cond_ex;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= 4'b0000;
        end else if (flag_wr) begin
            flags_q[3:2] <= ALUFlags[3:2];
            if (dp_sets_cv(cmd)) begin
                flags_q[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_MEM:  next_state = S_MEMADR;
                    OP_DP:   next_state = funct[5] ? S_EXECI : S_EXECR;
                    OP_BR:   next_state = S_BRANCH;
                    default: next_state = S_FETCH;   // op=11 is a no-op
                endcase
            end
            S_MEMADR: next_state = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state = S_MEMWB;
            S_EXECR:  next_state = S_ALUWB;
            S_EXECI:  next_state = S_ALUWB;
            default:  next_state = S_FETCH;          // MEMWB, MEMWR, ALUWB, BRANCH
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (Moore, with write enables qualified by CondEx)
    // ------------------------------------------------------------------
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcB    = SRCB_REG;
        ImmSrc     = IMM_DP;
        RegSrc     = 2'b00;
        ALUControl = ALU_AND;

        case (state)
            S_FETCH: begin
                // PC + 4 goes straight back to the PC while the IR loads
                IRWrite    = 1'b1;
                PCWrite    = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ALUControl = ALU_ADD;
                ResultSrc  = RES_ALU;
            end
            S_DECODE: begin
                // PC + 8 is formed so that reads of R15 see the ARM-visible PC
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ALUControl = ALU_ADD;
                ResultSrc  = RES_ALU;
            end
            S_MEMADR: begin
                // funct[3] is the U bit: add or subtract the offset
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_MEM;
                ALUControl = funct[3] ? ALU_ADD : ALU_SUB;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = cond_ex;
                PCWrite   = cond_ex & pc_is_rd;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_ex;
                RegSrc   = REGSRC_STR;
            end
            S_EXECR: begin
                ALUSrcB    = SRCB_REG;
                ALUControl = dp_alu_control(cmd);
            end
            S_EXECI: begin
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_DP;
                ALUControl = dp_alu_control(cmd);
            end
            S_ALUWB: begin
                // CMP only sets flags; it never writes a destination register
                ResultSrc = RES_ALUOUT;
                RegWrite  = cond_ex & (cmd != CMD_CMP);
                PCWrite   = cond_ex & pc_is_rd;
            end
            S_BRANCH: begin
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_BR;
                ALUControl = ALU_ADD;
                ResultSrc  = RES_ALU;
                PCWrite    = cond_ex;
            end
            default: begin
            end
        endcase

        // Reset forces FETCH immediately; its architectural writes must not
        // fire until reset is released.
        if (!reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed ARM sequences, a mid-instruction
// reset, then random instructions compared cycle by cycle against an instruction-level model.
module tb_multicycle_controller;

    typedef struct packed {
        logic       PCWrite;
        logic       AdrSrc;
        logic       MemWrite;
        logic       IRWrite;
        logic       RegWrite;
        logic       ALUSrcA;
        logic [1:0] ResultSrc;
        logic [1:0] ALUSrcB;
        logic [1:0] ImmSrc;
        logic [1:0] RegSrc;
        logic [3:0] ALUControl;
    } ctl_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] Instr;
    logic [3:0]  Rd;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [3:0]  ALUControl;
    logic [3:0]  Flags;

    int          n_chk = 0;
    int          n_err = 0;
    logic [3:0]  mflags = 4'b0000;   // model of the architectural NZCV register

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ResultSrc  (ResultSrc),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .Flags      (Flags)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Conditions come in pairs: odd codes are the negation of the even code before them.
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, r;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        return r ^ c[0];
    endfunction

    function automatic logic [3:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0010, 4'b1010: return 4'b0100;   // SUB, CMP
            4'b0000:          return 4'b0000;   // AND
            4'b1100:          return 4'b0001;   // ORR
            default:          return 4'b0011;   // ADD and everything else
        endcase
    endfunction

    function automatic int instr_len(input logic [11:0] ins);
        case (ins[7:6])
            2'b00:   return 4;
            2'b01:   return ins[0] ? 5 : 4;
            2'b10:   return 3;
            default: return 2;
        endcase
    endfunction

    // Expected controls for cycle k (0 = FETCH) of an instruction.
    function automatic ctl_t exp_ctl(input logic [11:0] ins, input logic [3:0] rd,
                                     input int k, input bit ce);
        ctl_t e;
        logic [5:0] f;
        bit to_pc;
        e = '0;
        f = ins[5:0];
        to_pc = (rd == 4'hF);
        if (k <= 1) begin
            e.ALUSrcA = 1'b1; e.ALUSrcB = 2'b10; e.ALUControl = 4'b0011; e.ResultSrc = 2'b10;
            if (k == 0) begin e.IRWrite = 1'b1; e.PCWrite = 1'b1; end
        end else if (ins[7:6] == 2'b01) begin
            if (k == 2) begin
                e.ALUSrcB = 2'b01; e.ImmSrc = 2'b01;
                e.ALUControl = f[3] ? 4'b0011 : 4'b0100;
            end else if (k == 3) begin
                e.AdrSrc = 1'b1;
                if (!f[0]) begin e.MemWrite = ce; e.RegSrc = 2'b10; end
            end else begin
                e.ResultSrc = 2'b01; e.RegWrite = ce; e.PCWrite = ce && to_pc;
            end
        end else if (ins[7:6] == 2'b00) begin
            if (k == 2) begin
                e.ALUSrcB = f[5] ? 2'b01 : 2'b00;
                e.ALUControl = alu_of(f[4:1]);
            end else begin
                e.RegWrite = ce && (f[4:1] != 4'b1010);
                e.PCWrite  = ce && to_pc;
            end
        end else begin
            e.ALUSrcB = 2'b01; e.ImmSrc = 2'b10; e.ALUControl = 4'b0011;
            e.ResultSrc = 2'b10; e.PCWrite = ce;
        end
        return e;
    endfunction

    // Runs one instruction from FETCH; ncyc > 0 stops after that many cycles.
    task automatic run_instr(input logic [11:0] ins, input logic [3:0] rd,
                             input logic [3:0] af, input bit fixed_af, input int ncyc);
        int   len;
        bit   ce;
        ctl_t e, got;
        len = instr_len(ins);
        if (ncyc > 0 && ncyc < len) len = ncyc;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            Instr    = ins;
            Rd       = rd;
            ALUFlags = fixed_af ? af : 4'($urandom);
            #1;
            ce  = cond_ok(ins[11:8], mflags);
            e   = exp_ctl(ins, rd, k, ce);
            got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA,
                   ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl};
            chk($sformatf("ctl i=%h rd=%h k=%0d", ins, rd, k), 32'(got), 32'(e));
            chk($sformatf("flags i=%h k=%0d", ins, k), 32'(Flags), 32'(mflags));
            if (ins[7:6] == 2'b00 && k == 2 && ins[0] && ce) begin
                mflags[3:2] = ALUFlags[3:2];
                if (ins[4:1] != 4'b0000 && ins[4:1] != 4'b1100)
                    mflags[1:0] = ALUFlags[1:0];
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] ins;
        logic [3:0]  rd;

        reset = 1'b0; Instr = 12'h000; Rd = 4'h0; ALUFlags = 4'hF;
        #3;
        chk("rst_irwrite",  32'(IRWrite),  32'd0);
        chk("rst_pcwrite",  32'(PCWrite),  32'd0);
        chk("rst_memwrite", 32'(MemWrite), 32'd0);
        chk("rst_regwrite", 32'(RegWrite), 32'd0);
        chk("rst_flags",    32'(Flags),    32'd0);
        chk("rst_fetch_srcb", 32'(ALUSrcB), 32'd2);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        // directed sequence
        run_instr(12'hE28, 4'h1, 4'h0, 1'b1, 0);   // ADD imm
        run_instr(12'hE05, 4'h2, 4'h4, 1'b1, 0);   // SUBS -> Z
        chk("subs_flags", 32'(Flags), 32'h4);
        run_instr(12'h0A0, 4'h0, 4'h0, 1'b1, 0);   // BEQ taken
        run_instr(12'h1A0, 4'h0, 4'h0, 1'b1, 0);   // BNE not taken
        run_instr(12'hE59, 4'h3, 4'h0, 1'b1, 0);   // LDR
        run_instr(12'hE58, 4'h3, 4'h0, 1'b1, 0);   // STR
        run_instr(12'hEC0, 4'h4, 4'h0, 1'b1, 0);   // op=11
        run_instr(12'hE59, 4'hF, 4'h0, 1'b1, 0);   // LDR into PC

        // asynchronous reset in the middle of MEMRD
        run_instr(12'hE59, 4'h5, 4'h0, 1'b1, 3);
        @(posedge clk);
        #2;
        chk("memrd_adrsrc", 32'(AdrSrc), 32'd1);
        reset = 1'b0;
        #1;
        mflags = 4'b0000;
        chk("arst_flags",    32'(Flags),    32'd0);
        chk("arst_adrsrc",   32'(AdrSrc),   32'd0);
        chk("arst_srcb",     32'(ALUSrcB),  32'd2);
        chk("arst_irwrite",  32'(IRWrite),  32'd0);
        chk("arst_pcwrite",  32'(PCWrite),  32'd0);
        chk("arst_memwrite", 32'(MemWrite), 32'd0);
        chk("arst_regwrite", 32'(RegWrite), 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        run_instr(12'hE28, 4'h1, 4'h0, 1'b1, 0);

        // random instructions
        for (int i = 0; i < 300; i++) begin
            ins[11:8] = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom);
            ins[7:6]  = 2'($urandom);
            ins[5:0]  = 6'($urandom);
            rd        = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            run_instr(ins, rd, 4'h0, 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
